map_row_reader: RTL and testbench

- Consumer end of the map row interface.
- Walks the display frame row by row and drives the row index to the map generator. Latches the returned wide row word, then serialises it one pixel per cycle to a downstream pixel sink over a valid/ready handshake.
- At each frame boundary it presents the next map select and pulses the generator's buffer-switch input, so map changes only take effect between frames.

---
 rtl/map_row_reader_pkg.sv | 26 ++
 rtl/map_row_shifter.sv | 65 ++++++
 rtl/map_row_reader.sv | 191 +++++++++++++++++++
 tb/tb_map_row_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_row_reader_pkg.sv
// Shared constants for the map row interface, used by both the map
// generator and the row reader.
// Pixel convention: a row word carries column 0 in its MSB (bit COLS-1);
// a pixel value of 1 is a wall and 0 is floor.
package map_row_reader_pkg;

  localparam int unsigned ROWS       = 480;
  localparam int unsigned COLS       = 1696;
  localparam int unsigned ROW_W      = 9;
  localparam int unsigned COL_W      = 11;
  localparam int unsigned SWB_CYCLES = 2;

  // Shifted into the vacated LSB; never presented because eol stops the walk
  localparam logic PIX_FLOOR = 1'b0;

  // Reader state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SWITCH    = 3'd1,
    ST_REQ       = 3'd2,
    ST_LOAD      = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_FRAME_END = 3'd5
  } state_e;

endpackage

// File: rtl/map_row_shifter.sv
// Row word load/shift register with its column counter and eol flag.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   load           - capture row_data, column back to 0
//   advance        - move to the next column (ignored on the last column)
//   row_data       - COLS-bit row word, column 0 in the MSB
//   msb            - pixel at the current column
//   col            - current column index
//   eol            - current column is the last one
// With neither load nor advance the register and counter hold.
module map_row_shifter #(
  parameter int unsigned COLS  = map_row_reader_pkg::COLS,
  parameter int unsigned COL_W = map_row_reader_pkg::COL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [COLS-1:0]  row_data,
  output logic             msb,
  output logic [COL_W-1:0] col,
  output logic             eol
);
  import map_row_reader_pkg::*;

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_PENULT = COL_W'(COLS - 2);

  logic [COLS-1:0]  sr_q, sr_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             eol_q, eol_d;

  // Next register contents
  always_comb begin
    sr_d  = sr_q;
    col_d = col_q;
    eol_d = eol_q;
    if (load) begin
      sr_d  = row_data;
      col_d = '0;
      eol_d = (COL_LAST == '0);
    end else if (advance && !eol_q) begin
      sr_d  = {sr_q[COLS-2:0], PIX_FLOOR};
      col_d = col_q + COL_W'(1);
      eol_d = (col_q == COL_PENULT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      col_q <= '0;
      eol_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      col_q <= col_d;
      eol_q <= eol_d;
    end
  end

  assign msb = sr_q[COLS-1];
  assign col = col_q;
  assign eol = eol_q;

endmodule

// File: rtl/map_row_reader.sv
// Consumer end of the map row interface: walks the frame row by row, fetches
// each row word from the map generator and streams it one pixel per cycle to
// a valid/ready sink. The map select only changes at frame boundaries,
// committed to the generator by a switch_buffer pulse.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   enable           - run request, sampled in IDLE and at frame end
//   next_map         - map select applied at the next frame boundary
//   row / row_data   - row index to the generator / row word back
//   map              - map select presented to the generator
//   switch_buffer    - buffer-switch strobe, rising edge commits map
//   pix_valid/ready  - pixel handshake to the sink
//   pix_data         - pixel value (1 = wall)
//   pix_col/pix_row  - pixel coordinates
//   sof / eol        - pixel (0,0) / last column of a row
//   frame_done       - one-cycle pulse after the last pixel is accepted
module map_row_reader #(
  parameter int unsigned ROWS       = map_row_reader_pkg::ROWS,
  parameter int unsigned COLS       = map_row_reader_pkg::COLS,
  parameter int unsigned ROW_W      = map_row_reader_pkg::ROW_W,
  parameter int unsigned COL_W      = map_row_reader_pkg::COL_W,
  parameter int unsigned SWB_CYCLES = map_row_reader_pkg::SWB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             next_map,
  output logic [ROW_W-1:0] row,
  input  logic [COLS-1:0]  row_data,
  output logic             map,
  output logic             switch_buffer,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_data,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             sof,
  output logic             eol,
  output logic             frame_done
);
  import map_row_reader_pkg::*;

  localparam int unsigned      SWB_W    = $clog2(SWB_CYCLES + 1);
  localparam logic [SWB_W-1:0] SWB_LAST = SWB_W'(SWB_CYCLES);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [SWB_W-1:0] swb_cnt_q, swb_cnt_d;
  logic             map_q, map_d;
  logic             swb_q, swb_d;
  logic             pix_valid_q, pix_valid_d;
  logic             sof_q, sof_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic             sh_load, sh_advance;
  logic             sh_msb, sh_eol;
  logic [COL_W-1:0] sh_col;

  assign accept = (state_q == ST_SHIFT) && pix_ready;

  map_row_shifter #(
    .COLS  (COLS),
    .COL_W (COL_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .advance  (sh_advance),
    .row_data (row_data),
    .msb      (sh_msb),
    .col      (sh_col),
    .eol      (sh_eol)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    row_d      = row_q;
    swb_cnt_d  = swb_cnt_q;
    map_d      = map_q;
    sof_d      = sof_q;
    sh_load    = 1'b0;
    sh_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          map_d   = next_map;
          state_d = ST_SWITCH;
        end
      end
      // First SWITCH cycle only settles map; the pulse follows it
      ST_SWITCH: begin
        if (swb_cnt_q == SWB_LAST) begin
          state_d = ST_REQ;
        end else begin
          swb_cnt_d = swb_cnt_q + SWB_W'(1);
        end
      end
      ST_REQ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sh_load = 1'b1;
        sof_d   = (row_cnt_q == '0);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (accept) begin
          sof_d = 1'b0;
          if (sh_eol) begin
            if (row_cnt_q == ROW_LAST) begin
              state_d = ST_FRAME_END;
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
              state_d   = ST_REQ;
            end
          end else begin
            sh_advance = 1'b1;
          end
        end
      end
      ST_FRAME_END: begin
        if (enable) begin
          map_d   = next_map;
          state_d = ST_SWITCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new frame restarts the pulse timer and the row walk
    if ((state_d == ST_SWITCH) && (state_q != ST_SWITCH)) begin
      swb_cnt_d = '0;
      row_cnt_d = '0;
    end

    // row changes on entry to REQ so it is stable for all of LOAD
    if (state_d == ST_REQ) begin
      row_d = row_cnt_d;
    end
  end

  assign swb_d        = (state_q == ST_SWITCH) && (swb_cnt_q != SWB_LAST);
  assign pix_valid_d  = (state_d == ST_SHIFT);
  assign frame_done_d = (state_d == ST_FRAME_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_cnt_q    <= '0;
      row_q        <= '0;
      swb_cnt_q    <= '0;
      map_q        <= 1'b0;
      swb_q        <= 1'b0;
      pix_valid_q  <= 1'b0;
      sof_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      row_q        <= row_d;
      swb_cnt_q    <= swb_cnt_d;
      map_q        <= map_d;
      swb_q        <= swb_d;
      pix_valid_q  <= pix_valid_d;
      sof_q        <= sof_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row           = row_q;
  assign map           = map_q;
  assign switch_buffer = swb_q;
  assign pix_valid     = pix_valid_q;
  assign pix_data      = sh_msb;
  assign pix_col       = sh_col;
  assign pix_row       = row_cnt_q;
  assign sof           = sof_q;
  assign eol           = sh_eol;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_map_row_reader.sv
// Scoreboard bench for map_row_reader with a behavioural map generator.
module tb_map_row_reader;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 1696;
  localparam int unsigned ROW_W = 9;
  localparam int unsigned COL_W = 11;
  localparam int unsigned SWB   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             next_map;
  logic [ROW_W-1:0] row;
  logic [COLS-1:0]  row_data;
  logic             map;
  logic             switch_buffer;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_data;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic             sof;
  logic             eol;
  logic             frame_done;
  logic [35:0]      all_outs;

  always #5 clk = ~clk;

  map_row_reader #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W),
    .SWB_CYCLES (SWB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .next_map      (next_map),
    .row           (row),
    .row_data      (row_data),
    .map           (map),
    .switch_buffer (switch_buffer),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_col       (pix_col),
    .pix_row       (pix_row),
    .sof           (sof),
    .eol           (eol),
    .frame_done    (frame_done)
  );

  assign all_outs = {row, map, switch_buffer, pix_valid, pix_data, pix_col,
                     pix_row, sof, eol, frame_done};

  // Map 1, even rows: 8 floor, 1680 wall, 8 floor. Otherwise a row/map mix.
  function automatic logic pix_exp(input int r, input int c, input logic m);
    if (m && (r % 2 == 0)) return (c >= 8) && (c < int'(COLS) - 8);
    return ((c * 7 + r * 3 + (m ? 2 : 0)) % 5) < 2;
  endfunction

  // Generator model: commits map on the rising edge of switch_buffer
  logic gen_map = 1'b0;
  logic sb_d1   = 1'b0;
  always @(posedge clk) begin
    sb_d1 <= (switch_buffer === 1'b1);
    if (switch_buffer === 1'b1 && !sb_d1) gen_map <= map;
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < int'(COLS); c++)
      row_data[int'(COLS) - 1 - c] = pix_exp(int'(row), c, gen_map);
  end

  typedef struct packed {
    logic [ROW_W-1:0] r_out;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic             d;
    logic             sof;
    logic             eol;
  } pix_t;

  pix_t exp_q[$];
  logic map_exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic m);
    map_exp_q.push_back(m);
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        pix_t e;
        e.r_out = ROW_W'(r);
        e.r     = ROW_W'(r);
        e.c     = COL_W'(c);
        e.d     = pix_exp(r, c, m);
        e.sof   = (r == 0) && (c == 0);
        e.eol   = (c == int'(COLS) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: pixel scoreboard plus handshake/timing checks
  pix_t cur, prev_out, e;
  logic prev_stall = 1'b0;
  logic gap_active = 1'b0;
  int   gap_cnt    = 0;
  logic last_final = 1'b0;
  logic in_frame   = 1'b0;
  logic frame_bad  = 1'b0;
  logic frame_map  = 1'b0;
  logic sb_prev    = 1'b0;
  logic map_prev   = 1'b0;
  int   sb_run     = 0;

  always @(negedge clk) begin
    cur.r_out = row;
    cur.r     = pix_row;
    cur.c     = pix_col;
    cur.d     = pix_data;
    cur.sof   = sof;
    cur.eol   = eol;
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
      gap_active = 1'b0;
      last_final = 1'b0;
      in_frame   = 1'b0;
      sb_prev    = 1'b0;
      sb_run     = 0;
      map_prev   = map;
    end else begin
      if (last_final) check("frame_done", 64'(frame_done), 64'(1));
      else if (frame_done === 1'b1) check("frame_done_spurious", 64'(frame_done), 64'(0));
      last_final = 1'b0;
      if (frame_done === 1'b1 && in_frame) begin
        check("mid_frame_map_sb", 64'(frame_bad), 64'(0));
        in_frame = 1'b0;
      end

      if (prev_stall) check("stall_hold", 64'({pix_valid, cur}), 64'({1'b1, prev_out}));

      if (gap_active) begin
        if (pix_valid === 1'b1) begin
          check("valid_gap", 64'(gap_cnt), 64'(2));
          gap_active = 1'b0;
        end else begin
          gap_cnt++;
          if (gap_cnt > 8) begin
            check("valid_gap_timeout", 64'(gap_cnt), 64'(2));
            gap_active = 1'b0;
          end
        end
      end

      if (in_frame && (switch_buffer !== 1'b0 || map !== frame_map)) frame_bad = 1'b1;

      if (switch_buffer === 1'b1 && !sb_prev) begin
        check("map_before_sb", 64'(map), 64'(map_prev));
        if (map_exp_q.size() == 0) check("sb_unexpected", 64'(switch_buffer), 64'(0));
        else check("map_value", 64'(map), 64'(map_exp_q.pop_front()));
        sb_run = 1;
      end else if (switch_buffer === 1'b1) begin
        sb_run++;
      end else if (sb_prev) begin
        check("sb_len", 64'(sb_run), 64'(SWB));
        check("row0_at_req", 64'({pix_valid, row}), 64'(0));
        gap_active = 1'b1;
        gap_cnt    = 1;
      end

      if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 64'(pix_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("pix r%0d c%0d", e.r, e.c), 64'(cur), 64'(e));
          if (e.sof) begin
            in_frame  = 1'b1;
            frame_bad = 1'b0;
            frame_map = map;
          end
          if (e.eol) begin
            if (e.r == ROW_W'(ROWS - 1)) last_final = 1'b1;
            else begin
              gap_active = 1'b1;
              gap_cnt    = 0;
            end
          end
        end
      end

      prev_stall = (pix_valid === 1'b1) && (pix_ready === 1'b0);
      prev_out   = cur;
      sb_prev    = (switch_buffer === 1'b1);
      map_prev   = map;
    end
  end

  // Sink: always ready, or 50% random ready
  logic rand_ready = 1'b0;
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_sb(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (switch_buffer !== 1'b1 && n < budget);
    check("sb_rise_seen", 64'(switch_buffer), 64'(1));
  endtask

  task automatic wait_frame_done(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < budget);
    check("frame_done_seen", 64'(frame_done), 64'(1));
  endtask

  task automatic wait_row(input int r, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (pix_row !== ROW_W'(r) && n < budget);
    check("row_reached", 64'(pix_row), 64'(r));
  endtask

  task automatic wait_pix(input int r, input int c, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(pix_valid === 1'b1 && pix_row === ROW_W'(r) && pix_col === COL_W'(c)) && n < budget);
    check("pix_reached", 64'({pix_row, pix_col}), 64'({ROW_W'(r), COL_W'(c)}));
  endtask

  logic idle_bad;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    next_map = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(all_outs), 64'(0));

    // Frame 1: map 1, sink always ready; frame 2 follows back-to-back with map 0
    @(posedge clk); #1;
    reset    = 1'b0;
    enable   = 1'b1;
    next_map = 1'b1;
    push_frame(1'b1);
    wait_sb(50);
    @(posedge clk); #1;
    next_map = 1'b0;
    push_frame(1'b0);
    wait_frame_done(30000);

    // Frame 2: random stalls, enable dropped and next_map changed mid-frame
    rand_ready = 1'b1;
    wait_row(2, 40000);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_row(4, 40000);
    @(posedge clk); #1;
    next_map = 1'b1;
    wait_frame_done(60000);
    rand_ready = 1'b0;

    idle_bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (switch_buffer !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0) idle_bad = 1'b1;
    end
    check("idle_quiet", 64'(idle_bad), 64'(0));
    check("row_held_idle", 64'(row), 64'(ROWS - 1));

    // Frame 3: abandoned by reset at row 3, column 500
    @(posedge clk); #1;
    enable   = 1'b1;
    next_map = 1'b1;
    push_frame(1'b1);
    wait_sb(50);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_pix(3, 500, 20000);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset_outputs", 64'(all_outs), 64'(0));

    // Frame 4: restart from row 0 after the reset
    @(posedge clk); #1;
    reset    = 1'b0;
    enable   = 1'b1;
    next_map = 1'b0;
    push_frame(1'b0);
    wait_sb(50);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_frame_done(30000);

    repeat (5) @(negedge clk);
    check("pix_queue_drained", 64'(exp_q.size()), 64'(0));
    check("map_queue_drained", 64'(map_exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
